// File: rtl/matrix_load_pkg.sv
// Shared types and helpers for the matrix load sequencer and its index counter.
package matrix_load_pkg;

  localparam int INDEX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } mls_state_t;

  // A session must load at least one layer and no more than the storage holds.
  function automatic logic layers_legal(input logic [INDEX_W-1:0] n,
                                        input int                 max_layers);
    logic [INDEX_W-1:0] max_v;
    max_v = max_layers[INDEX_W-1:0];
    return (n != '0) && (n <= max_v);
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// (layer, row) address counter: row runs 0..SIZE-1, then wraps and bumps the layer.
module matrix_index_counter
  import matrix_load_pkg::*;
#(
  parameter int SIZE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  output logic [INDEX_W-1:0] layer,
  output logic [INDEX_W-1:0] row,
  output logic               last_row
);

  localparam logic [INDEX_W-1:0] ROW_MAX = INDEX_W'(SIZE - 1);
  localparam logic [INDEX_W-1:0] ONE     = INDEX_W'(1);

  assign last_row = (row == ROW_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      layer <= '0;
      row   <= '0;
    end else if (clear) begin
      layer <= '0;
      row   <= '0;
    end else if (step) begin
      if (last_row) begin
        row   <= '0;
        layer <= layer + ONE;
      end else begin
        row <= row + ONE;
      end
    end
  end

endmodule

// File: rtl/matrix_load_sequencer.sv
// Load-session sequencer: accepts rows on a valid/ready stream and issues one
// registered storage write per accepted row at (layer, row) addresses.
module matrix_load_sequencer
  import matrix_load_pkg::*;
#(
  parameter int SIZE   = 3,
  parameter int LAYERS = 4,
  parameter int DATA_W = 96
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INDEX_W-1:0] num_layers,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               wr_en,
  output logic [INDEX_W-1:0] wr_layer,
  output logic [INDEX_W-1:0] wr_row,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic               error,
  output mls_state_t         state
);

  localparam logic [INDEX_W-1:0] ONE = INDEX_W'(1);

  mls_state_t         state_next;
  logic [INDEX_W-1:0] layers_q;
  logic [INDEX_W-1:0] cnt_layer;
  logic [INDEX_W-1:0] cnt_row;
  logic               cnt_last_row;
  logic               start_legal;
  logic               start_ok;
  logic               hs;
  logic               final_row;

  // Stream handshake: a row transfers on any edge where in_valid and in_ready
  // are both high; in_ready depends only on state, never on in_valid.
  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign hs       = in_valid & in_ready;

  assign start_legal = layers_legal(num_layers, LAYERS);
  assign start_ok    = (state == IDLE) & start & start_legal;
  assign final_row   = cnt_last_row & (cnt_layer == (layers_q - ONE));

  matrix_index_counter #(
    .SIZE(SIZE)
  ) u_index (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .step    (hs),
    .layer   (cnt_layer),
    .row     (cnt_row),
    .last_row(cnt_last_row)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = LOAD;
      // Abort takes priority over a same-cycle final handshake.
      LOAD: begin
        if (abort)                state_next = IDLE;
        else if (hs && final_row) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      layers_q <= '0;
      error    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        error <= ~start_legal;
        if (start_legal) layers_q <= num_layers;
      end
    end
  end

  // Address/data hold their last values between writes; only wr_en pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_layer <= '0;
      wr_row   <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= hs;
      if (hs) begin
        wr_layer <= cnt_layer;
        wr_row   <= cnt_row;
        wr_data  <= in_data;
      end
    end
  end

endmodule
